rx_frame_checker: RTL and testbench
===================================

Name: rx_frame_checker

Overview:
UART receive-side frame checker that supersedes the single stop-bit checker. It is driven by the RX sampler's per-bit strobe and tracks frame position itself: start, DATA_WIDTH data bits, optional parity and 1 or 2 stop bits. It deserialises data, checks start, parity and stop bits, and delivers a validated byte or a frame-error pulse. Saturating error counters feed the register file.

Parameters:
DATA_WIDTH, 8, data bits per frame, legal range 5..9
ERR_CNT_WIDTH, 8, width of each saturating error counter

Ports:
CLK  in  1  system clock; all logic on rising edge
RST_n  in  1  synchronous active-low reset
chk_en  in  1  strobe, one cycle per bit; sampled_bit valid this cycle
sampled_bit  in  1  majority-voted bit from sampler
cfg_par_en  in  1  1 = parity bit present
cfg_par_typ  in  1  0 = even, 1 = odd
cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits
cnt_clr  in  1  clears both error counters
data_out  out  DATA_WIDTH  last good frame's data
data_valid  out  1  one-cycle pulse, data_out updated
frame_err  out  1  one-cycle pulse, completed frame had parity or stop error
par_err  out  1  parity result of last completed frame (level)
stp_err  out  1  stop result of last completed frame (level)
strt_glitch  out  1  one-cycle pulse, start sample was 1
busy  out  1  high in any state other than IDLE
par_err_cnt  out  ERR_CNT_WIDTH  saturating parity-error count
stp_err_cnt  out  ERR_CNT_WIDTH  saturating stop-error count

Behaviour:
- Reset: RST_n sampled low at a rising edge forces state IDLE and clears every output, counter, shift register and internal flag. This includes a reset mid-frame.
- States: IDLE, DATA, PARITY, STOP. Transitions happen only on cycles with chk_en=1.
- IDLE, chk_en: sampled_bit=1 gives strt_glitch=1 next cycle and the block stays in IDLE. sampled_bit=0 moves to DATA with bit_cnt=0, clears the frame's internal parity and stop flags, and latches cfg_par_en, cfg_par_typ and cfg_stop2. Config changes mid-frame are ignored.
- DATA, chk_en: data is LSB first. Shift the register right and insert sampled_bit at the MSB. XOR sampled_bit into the parity accumulator and increment bit_cnt. After DATA_WIDTH bits, move to PARITY if parity is enabled, otherwise to STOP with stop_cnt=0.
- PARITY, chk_en: internal parity flag = sampled_bit XOR accumulator XOR par_typ. Move to STOP with stop_cnt=0.
- STOP, chk_en: sampled_bit=0 sets the sticky internal stop flag. If stop_cnt equals the number of stop bits minus 1, the frame completes; otherwise stop_cnt increments.
- Completion (on the edge at the final stop strobe): state becomes IDLE. par_err and stp_err load the frame flags and hold until the next completion. If there are no errors, data_out loads the shift register and data_valid pulses. Otherwise frame_err pulses and data_out is unchanged. Outputs are visible the cycle after the final stop strobe.
- Counters: par_err_cnt increments when a frame completes with par_err=1; stp_err_cnt likewise for stp_err. Both can increment on the same frame. Each counter saturates at all-ones. cnt_clr has priority over a simultaneous increment.
- chk_en=0: state and data hold. Pulse outputs are high for exactly one cycle.
- Glitch pulses and aborted frames (reset) do not touch the counters.

Decomposition:
- Shared package uart_pkg:
  - State enum constants IDLE/DATA/PARITY/STOP.
  - Parity type constants PAR_EVEN=0, PAR_ODD=1.
  - Stop-count constants.
- Sub-module sat_counter (parameter WIDTH; inputs inc, clr; output count), instantiated twice. Everything else is inline.

Test Plan:
- Reset: hold RST_n=0 for 2 edges with chk_en toggling → all outputs and counters 0, busy=0.
- Good frame, no parity, 1 stop, 0xA5: strobe bits 0,1,0,1,0,0,1,0,1,1 → data_out=0xA5, data_valid high one cycle after last strobe, par_err=stp_err=frame_err=0.
- Even parity, 0x55, parity bit sent 1 → par_err=1, frame_err pulse, par_err_cnt=1, data_out keeps 0xA5, no data_valid.
- cfg_stop2=1, 0x3C, stops 1 then 0 → stp_err=1, stp_err_cnt=1. Next good frame 0x0F → stp_err=0, stp_err_cnt stays 1, data_out=0x0F.
- Start glitch: one strobe with sampled_bit=1 in IDLE → strt_glitch single pulse, busy=0. A following frame 0x81 is received correctly.
- ERR_CNT_WIDTH=2: five stop-error frames → stp_err_cnt=3. cnt_clr coincident with a sixth error completion → 0. Reset after 4 data bits, then full frame 0xC3 → data_out=0xC3 with no error.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive-side types and constants
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Index of the last stop bit for one / two stop-bit frames
  localparam logic STOP_LAST_ONE = 1'b0;
  localparam logic STOP_LAST_TWO = 1'b1;

  function automatic logic exp_par_bit(input logic acc, input logic typ);
    return (typ == PAR_EVEN) ? acc : ~acc;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with clear priority
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rx_frame_checker.sv
// rtl/rx_frame_checker.sv - UART receive frame checker: deserialise, check start/parity/stop
module rx_frame_checker
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     chk_en,
  input  logic                     sampled_bit,
  input  logic                     cfg_par_en,
  input  logic                     cfg_par_typ,
  input  logic                     cfg_stop2,
  input  logic                     cnt_clr,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  output logic                     frame_err,
  output logic                     par_err,
  output logic                     stp_err,
  output logic                     strt_glitch,
  output logic                     busy,
  output logic [ERR_CNT_WIDTH-1:0] par_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] stp_err_cnt
);

  localparam int BCW = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_acc_q, par_acc_d;
  logic                    par_flag_q, par_flag_d;
  logic                    stp_flag_q, stp_flag_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    stop2_q, stop2_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    data_valid_q, data_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;
  logic                    strt_glitch_q, strt_glitch_d;
  logic                    par_inc, stp_inc;
  logic                    stp_final;

  // Stop flag including the current sample, so the last stop bit counts on completion
  assign stp_final = stp_flag_q | ~sampled_bit;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    stop_cnt_d    = stop_cnt_q;
    shift_d       = shift_q;
    par_acc_d     = par_acc_q;
    par_flag_d    = par_flag_q;
    stp_flag_d    = stp_flag_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    stop2_d       = stop2_q;
    data_out_d    = data_out_q;
    par_err_d     = par_err_q;
    stp_err_d     = stp_err_q;
    data_valid_d  = 1'b0;
    frame_err_d   = 1'b0;
    strt_glitch_d = 1'b0;
    par_inc       = 1'b0;
    stp_inc       = 1'b0;

    if (chk_en) begin
      case (state_q)
        IDLE: begin
          if (sampled_bit) begin
            strt_glitch_d = 1'b1;
          end else begin
            state_d    = DATA;
            bit_cnt_d  = '0;
            par_acc_d  = 1'b0;
            par_flag_d = 1'b0;
            stp_flag_d = 1'b0;
            par_en_d   = cfg_par_en;
            par_typ_d  = cfg_par_typ;
            stop2_d    = cfg_stop2;
          end
        end
        DATA: begin
          shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          par_acc_d = par_acc_q ^ sampled_bit;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = par_en_q ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end
        end
        PARITY: begin
          par_flag_d = sampled_bit ^ exp_par_bit(par_acc_q, par_typ_q);
          state_d    = STOP;
          stop_cnt_d = 1'b0;
        end
        STOP: begin
          stp_flag_d = stp_final;
          if (stop_cnt_q == (stop2_q ? STOP_LAST_TWO : STOP_LAST_ONE)) begin
            state_d   = IDLE;
            par_err_d = par_flag_q;
            stp_err_d = stp_final;
            par_inc   = par_flag_q;
            stp_inc   = stp_final;
            if (!par_flag_q && !stp_final) begin
              data_out_d   = shift_q;
              data_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      stop_cnt_q    <= 1'b0;
      shift_q       <= '0;
      par_acc_q     <= 1'b0;
      par_flag_q    <= 1'b0;
      stp_flag_q    <= 1'b0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      stop2_q       <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      strt_glitch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      stop_cnt_q    <= stop_cnt_d;
      shift_q       <= shift_d;
      par_acc_q     <= par_acc_d;
      par_flag_q    <= par_flag_d;
      stp_flag_q    <= stp_flag_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      stop2_q       <= stop2_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_err_q   <= frame_err_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      strt_glitch_q <= strt_glitch_d;
    end
  end

  sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_par_cnt (
    .clk   (CLK),
    .rst_n (RST_n),
    .inc   (par_inc),
    .clr   (cnt_clr),
    .count (par_err_cnt)
  );

  sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_stp_cnt (
    .clk   (CLK),
    .rst_n (RST_n),
    .inc   (stp_inc),
    .clr   (cnt_clr),
    .count (stp_err_cnt)
  );

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign strt_glitch = strt_glitch_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_rx_frame_checker.sv
// tb/tb_rx_frame_checker.sv - scoreboard bench for rx_frame_checker
module tb_rx_frame_checker;

  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          chk_en = 1'b0;
  logic          sampled_bit = 1'b1;
  logic          cfg_par_en = 1'b0;
  logic          cfg_par_typ = 1'b0;
  logic          cfg_stop2 = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid, frame_err, par_err, stp_err, strt_glitch, busy;
  logic [CW-1:0] par_err_cnt, stp_err_cnt;

  always #5 CLK = ~CLK;

  rx_frame_checker #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .chk_en      (chk_en),
    .sampled_bit (sampled_bit),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_typ (cfg_par_typ),
    .cfg_stop2   (cfg_stop2),
    .cnt_clr     (cnt_clr),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .strt_glitch (strt_glitch),
    .busy        (busy),
    .par_err_cnt (par_err_cnt),
    .stp_err_cnt (stp_err_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          good;
    logic          perr;
    logic          serr;
    int            pcnt;
    int            scnt;
  } exp_t;

  exp_t          sb_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] m_data = '0;
  int            m_pcnt = 0;
  int            m_scnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST_n && (data_valid || frame_err)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("data_valid", 32'(data_valid), 32'(e.good));
        check("frame_err", 32'(frame_err), 32'(!e.good));
        check("data_out", 32'(data_out), 32'(e.data));
        check("par_err", 32'(par_err), 32'(e.perr));
        check("stp_err", 32'(stp_err), 32'(e.serr));
        check("par_err_cnt", 32'(par_err_cnt), 32'(e.pcnt));
        check("stp_err_cnt", 32'(stp_err_cnt), 32'(e.scnt));
      end
    end
  end

  task automatic strobe(input logic b);
    chk_en      = 1'b1;
    sampled_bit = b;
    @(negedge CLK);
    chk_en  = 1'b0;
    cnt_clr = 1'b0;
    @(negedge CLK);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic flip, input logic s2, input logic sb1,
                            input logic sb2, input logic clr);
    exp_t e;
    logic perr, serr;
    perr = pe & flip;
    serr = !sb1 || (s2 && !sb2);
    if (!perr && !serr) m_data = d;
    if (clr) begin
      m_pcnt = 0;
      m_scnt = 0;
    end else begin
      if (perr && m_pcnt < CMAX) m_pcnt++;
      if (serr && m_scnt < CMAX) m_scnt++;
    end
    e.data = m_data; e.good = !perr && !serr; e.perr = perr; e.serr = serr;
    e.pcnt = m_pcnt; e.scnt = m_scnt;
    sb_q.push_back(e);

    cfg_par_en = pe; cfg_par_typ = pt; cfg_stop2 = s2;
    strobe(1'b0);
    // Config flipped after the start bit must not affect this frame
    cfg_par_en = ~pe; cfg_par_typ = ~pt; cfg_stop2 = ~s2;
    for (int i = 0; i < DW; i++) strobe(d[i]);
    if (pe) strobe((^d) ^ pt ^ flip);
    if (s2) begin
      strobe(sb1);
      cnt_clr = clr;
      strobe(sb2);
    end else begin
      cnt_clr = clr;
      strobe(sb1);
    end
    check("pulse_one_cycle", 32'({data_valid, frame_err}), 32'd0);
    check("busy_after_frame", 32'(busy), 32'd0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    @(negedge CLK); chk_en = 1'b1; sampled_bit = 1'b0;
    @(negedge CLK); chk_en = 1'b0;
    @(negedge CLK);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_pulses", 32'({data_valid, frame_err, strt_glitch}), 32'd0);
    check("rst_levels", 32'({par_err, stp_err, busy}), 32'd0);
    check("rst_counters", 32'({par_err_cnt, stp_err_cnt}), 32'd0);
    RST_n = 1'b1;
    @(negedge CLK);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    chk_en = 1'b1; sampled_bit = 1'b1;
    @(negedge CLK);
    chk_en = 1'b0;
    check("glitch_pulse", 32'(strt_glitch), 32'd1);
    check("glitch_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    check("glitch_one_cycle", 32'(strt_glitch), 32'd0);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      send_frame(8'($urandom_range(0, 255)), logic'(i == 2), 1'b0, 1'b1, 1'b0,
                 1'b0, 1'b1, 1'b0);
    end
    check("stp_cnt_saturated", 32'(stp_err_cnt), 32'(CMAX));
    send_frame(8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("cnt_clr_priority", 32'({par_err_cnt, stp_err_cnt}), 32'd0);

    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    RST_n = 1'b0;
    @(negedge CLK);
    RST_n = 1'b1;
    m_data = '0; m_pcnt = 0; m_scnt = 0;
    check("midframe_rst_busy", 32'(busy), 32'd0);
    check("midframe_rst_data", 32'(data_out), 32'd0);
    check("midframe_rst_levels", 32'({par_err, stp_err}), 32'd0);
    @(negedge CLK);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    repeat (3) @(negedge CLK);
    check("final_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
